cargador_operandos: RTL
=======================

Name: cargador_operandos

Overview:
- Operand-entry sequencer that drives the combinational ALU (and/or/xor/suma ops) from board switches and one push-button.
- Collects expresionA, expresionB and opcode over three button presses, then presents them to the ALU with a valido strobe.
- Latches the ALU resultado/cero one cycle later and holds them for display until the next press.
- Sits between the board I/O (debounced, synchronized buttons) and the ALU top.

Parameters:
- M, 4, operand/result width in bits.
- OPW, 2, opcode width; OPW <= M required (elaboration $error otherwise).
- N_OPS, 4, number of legal opcodes; codes >= N_OPS are invalid.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- entrada  input  M  switch value sampled on each accepted press.
- cargar  input  1  debounced, synchronized load button (level).
- cancelar  input  1  synchronous abort (level), priority over cargar.
- expresionA  output  M  registered operand A to ALU.
- expresionB  output  M  registered operand B to ALU.
- operacion  output  OPW  registered opcode to ALU.
- valido  output  1  one-cycle strobe: operands/opcode stable, ALU evaluating.
- resultado_in  input  M  ALU result (combinational from expresionA/B/operacion).
- cero_in  input  1  ALU zero flag.
- resultado_reg  output  M  latched result for display.
- cero_reg  output  1  latched zero flag.
- listo  output  1  result latched and displayed.
- error_op  output  1  last opcode entry was invalid.
- estado  output  3  current FSM state encoding, for LEDs.

Behaviour:
- Reset (async, rst_n=0):
  - All data outputs 0: expresionA, expresionB, operacion, resultado_reg, cero_reg, valido, listo, error_op.
  - State ESPERA_A.
  - Edge-detector history register resets to 1, so a button held through reset produces no press.
- Press pulse: press = cargar & ~cargar_q; cargar_q registered every cycle. One pulse per rising edge of cargar, independent of hold time.
- States and transitions (all on rising clk):
  - ESPERA_A: on press, expresionA <= entrada; listo <= 0; go ESPERA_B.
  - ESPERA_B: on press, expresionB <= entrada; go ESPERA_OP.
  - ESPERA_OP: on press:
    - If entrada[OPW-1:0] < N_OPS: operacion <= entrada[OPW-1:0]; error_op <= 0; go EJECUTA.
    - Else: error_op <= 1; operacion unchanged; remain ESPERA_OP.
  - EJECUTA: exactly one cycle; valido = 1 (Moore output); go CAPTURA.
  - CAPTURA: resultado_reg <= resultado_in; cero_reg <= cero_in; listo <= 1; go MUESTRA.
  - MUESTRA: outputs held; on press, listo <= 0, go ESPERA_A. This press does not load A.
- Latency: ESPERA_OP press to listo=1 is 3 clk edges. The ALU sees stable operands for at least 2 cycles before capture.
- cancelar=1 in any state:
  - Next state ESPERA_A; listo <= 0; error_op <= 0; valido forced 0 that cycle.
  - expresionA, expresionB, operacion, resultado_reg and cero_reg retain their values.
  - A coincident press is ignored.
- Press in EJECUTA or CAPTURA is ignored (dropped, not queued).
- Operand registers change only on an accepted press. ALU inputs never glitch during EJECUTA or CAPTURA.
- Width rules:
  - No arithmetic in this block.
  - Opcode is the low OPW bits of entrada; upper bits are ignored.
  - resultado_in is captured unmodified.
- Reset mid-operation: immediate async return to the reset values above. No partial capture survives.
- estado encoding: ESPERA_A=0, ESPERA_B=1, ESPERA_OP=2, EJECUTA=3, CAPTURA=4, MUESTRA=5.

Decomposition:
- Shared package alu_pkg holds:
  - estado_t enum (3-bit, encodings above).
  - Opcode constants OP_AND=0, OP_OR=1, OP_XOR=2, OP_SUMA=3.
  - N_OPS default.
- One sub-module: detector_flanco, a rising-edge pulse generator with a reset-to-1 history flop. It is reusable for the cancelar and display buttons.
- FSM and datapath registers live in cargador_operandos.

Test Plan:
- Nominal OR (M=4): reset, then presses with entrada=4'b1010, 4'b0101, 4'b0001; ALU model OR.
  - valido high exactly one cycle.
  - 2 cycles later: resultado_reg=4'b1111, cero_reg=0, listo=1, estado=5.
- Zero result: A=4'b1100, B=4'b0011, op=OP_AND.
  - resultado_reg=4'b0000, cero_reg=1, listo=1.
- Invalid opcode (N_OPS=3): op entry entrada=4'b0011.
  - error_op=1, estado stays 2, valido never asserts.
  - A following press with entrada=4'b0001 gives error_op=0, then normal EJECUTA.
- Held button: cargar high for 20 cycles in ESPERA_A.
  - Only A is loaded; estado=1.
  - Assert cargar during reset and release reset: no load occurs.
- Cancel: cancelar asserted together with a press in ESPERA_OP.
  - estado=0, listo=0, error_op=0.
  - expresionA/B keep their loaded values; no valido.
- Async reset mid-flow: drop rst_n while in CAPTURA (between edges).
  - All outputs are 0 immediately, without waiting for a clock edge.
  - estado=0 after release; first press loads A.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding and opcode constants.
package alu_pkg;

    typedef enum logic [2:0] {
        ESPERA_A  = 3'd0,
        ESPERA_B  = 3'd1,
        ESPERA_OP = 3'd2,
        EJECUTA   = 3'd3,
        CAPTURA   = 3'd4,
        MUESTRA   = 3'd5
    } estado_t;

    localparam logic [1:0] OP_AND  = 2'd0;
    localparam logic [1:0] OP_OR   = 2'd1;
    localparam logic [1:0] OP_XOR  = 2'd2;
    localparam logic [1:0] OP_SUMA = 2'd3;

    localparam int N_OPS_DEF = 4;

endpackage

// File: rtl/detector_flanco.sv
// Rising-edge pulse generator. History resets to 1 so a level held through reset
// never produces a pulse.
module detector_flanco (
    input  logic clk,
    input  logic rst_n,
    input  logic senal,
    output logic pulso
);

    logic historia;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            historia <= 1'b1;
        end else begin
            historia <= senal;
        end
    end

    assign pulso = senal & ~historia;

endmodule

// File: rtl/cargador_operandos.sv
// Operand-entry sequencer: collects A, B and opcode over three presses, strobes the
// ALU for one cycle, then latches and holds its result until the next press.
module cargador_operandos
    import alu_pkg::*;
#(
    parameter int M     = 4,
    parameter int OPW   = 2,
    parameter int N_OPS = N_OPS_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [M-1:0]   entrada,
    input  logic           cargar,
    input  logic           cancelar,
    output logic [M-1:0]   expresionA,
    output logic [M-1:0]   expresionB,
    output logic [OPW-1:0] operacion,
    output logic           valido,
    input  logic [M-1:0]   resultado_in,
    input  logic           cero_in,
    output logic [M-1:0]   resultado_reg,
    output logic           cero_reg,
    output logic           listo,
    output logic           error_op,
    output logic [2:0]     estado
);

    if (OPW > M) begin : g_opw_check
        $error("cargador_operandos: OPW must not exceed M");
    end

    estado_t state_q, state_d;
    logic    press;
    logic    op_legal;
    logic    carga_a, carga_b, carga_op, rechazo_op, captura, salir, abortar;

    detector_flanco u_flanco_cargar (
        .clk   (clk),
        .rst_n (rst_n),
        .senal (cargar),
        .pulso (press)
    );

    assign op_legal = 32'(entrada[OPW-1:0]) < 32'(N_OPS);

    // cancelar wins over any press; presses in EJECUTA/CAPTURA are simply dropped.
    always_comb begin
        state_d    = state_q;
        carga_a    = 1'b0;
        carga_b    = 1'b0;
        carga_op   = 1'b0;
        rechazo_op = 1'b0;
        captura    = 1'b0;
        salir      = 1'b0;
        abortar    = 1'b0;
        valido     = 1'b0;
        if (cancelar) begin
            abortar = 1'b1;
            state_d = ESPERA_A;
        end else begin
            case (state_q)
                ESPERA_A: if (press) begin
                    carga_a = 1'b1;
                    state_d = ESPERA_B;
                end
                ESPERA_B: if (press) begin
                    carga_b = 1'b1;
                    state_d = ESPERA_OP;
                end
                ESPERA_OP: if (press) begin
                    if (op_legal) begin
                        carga_op = 1'b1;
                        state_d  = EJECUTA;
                    end else begin
                        rechazo_op = 1'b1;
                    end
                end
                EJECUTA: begin
                    valido  = 1'b1;
                    state_d = CAPTURA;
                end
                CAPTURA: begin
                    captura = 1'b1;
                    state_d = MUESTRA;
                end
                MUESTRA: if (press) begin
                    salir   = 1'b1;
                    state_d = ESPERA_A;
                end
                default: state_d = ESPERA_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ESPERA_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expresionA    <= '0;
            expresionB    <= '0;
            operacion     <= '0;
            resultado_reg <= '0;
            cero_reg      <= 1'b0;
            listo         <= 1'b0;
            error_op      <= 1'b0;
        end else begin
            if (carga_a)  expresionA <= entrada;
            if (carga_b)  expresionB <= entrada;
            if (carga_op) operacion  <= entrada[OPW-1:0];
            if (captura) begin
                resultado_reg <= resultado_in;
                cero_reg      <= cero_in;
            end
            if (abortar || carga_a || salir) begin
                listo <= 1'b0;
            end else if (captura) begin
                listo <= 1'b1;
            end
            if (abortar || carga_op) begin
                error_op <= 1'b0;
            end else if (rechazo_op) begin
                error_op <= 1'b1;
            end
        end
    end

    assign estado = state_q;

endmodule
